// File: rtl/div_iter_32.sv
// ============================================================================
// Module      : div_iter_32
// Description : Iterative 32-bit radix-2 restoring divider for div/mod,
//               signed and unsigned, with valid/ready request and response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        sign,
    input  logic        cancel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] C_LAST_ITER = 5'd31;

    state_t      state_q, state_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic        sign_q, sign_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_res_q, quo_res_d;
    logic [31:0] rem_res_q, rem_res_d;

    logic [33:0] w_rem_shift;
    logic [33:0] w_trial;
    logic        w_borrow;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic s);
        return (s && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // One trial subtract per iteration; bit 33 of the difference is the borrow.
    assign w_rem_shift = {rem_q, quo_q[31]};
    assign w_trial     = w_rem_shift - {2'b00, div_q};
    assign w_borrow    = w_trial[33];

    always_comb begin
        state_d   = state_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        sign_d    = sign_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        quo_res_d = quo_res_q;
        rem_res_d = rem_res_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !cancel) begin
                    src1_d  = src1;
                    src2_d  = src2;
                    sign_d  = sign;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                div_d   = magnitude(src2_q, sign_q);
                quo_d   = magnitude(src1_q, sign_q);
                rem_d   = 33'd0;
                cnt_d   = 5'd0;
                qneg_d  = sign_q & (src1_q[31] ^ src2_q[31]);
                rneg_d  = sign_q & src1_q[31];
                dz_d    = (src2_q == 32'd0);
                state_d = S_CALC;
            end
            S_CALC: begin
                if (!w_borrow) begin
                    rem_d = w_trial[32:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = w_rem_shift[32:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == C_LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Divide-by-zero returns all-ones and the raw dividend for both signednesses.
                if (dz_q) begin
                    quo_res_d = 32'hFFFF_FFFF;
                    rem_res_d = src1_q;
                end else begin
                    quo_res_d = qneg_q ? (~quo_q + 32'd1) : quo_q;
                    rem_res_d = rneg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush overrides everything, including a pending output handshake.
        if (cancel && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            src1_q    <= 32'd0;
            src2_q    <= 32'd0;
            sign_q    <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            div_q     <= 32'd0;
            cnt_q     <= 5'd0;
            quo_res_q <= 32'd0;
            rem_res_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            sign_q    <= sign_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            quo_res_q <= quo_res_d;
            rem_res_q <= rem_res_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = quo_res_q;
    assign remainder = rem_res_q;

endmodule

`default_nettype wire

// File: tb/tb_div_iter_32.sv
// ============================================================================
// Module      : tb_div_iter_32
// Description : Self-checking bench for div_iter_32 against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_iter_32;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        sign;
    logic        cancel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks;
    int n_err;

    div_iter_32 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .sign      (sign),
        .cancel    (cancel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; SV '/' and '%' truncate toward zero.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("issue_timeout", 32'(t), 32'd0);
        src1     = a;
        src2     = b;
        sign     = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        int lat;
        logic [31:0] eq, er;
        model(a, b, s, eq, er);
        issue(a, b, s);
        wait_result(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd35);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int rose;
        int mode;
        logic [31:0] ra, rb, eq, er;
        logic        rs;

        n_checks  = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        src1      = 32'd0;
        src2      = 32'd0;
        sign      = 1'b0;
        cancel    = 1'b0;
        out_ready = 1'b1;

        #2;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op("u_100_7", 32'd100, 32'd7, 1'b0);
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("u_dz", 32'h1234_5678, 32'd0, 1'b0);
        run_op("s_dz", 32'h1234_5678, 32'd0, 1'b1);
        run_op("s_dz_neg", 32'h8765_4321, 32'd0, 1'b1);
        run_op("s_pos_neg", 32'd100, 32'hFFFF_FFF9, 1'b1);
        run_op("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        model(32'd1000, 32'd33, 1'b0, eq, er);
        issue(32'd1000, 32'd33, 1'b0);
        wait_result(lat);
        chk("bp_latency", 32'(lat), 32'd35);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_quotient", quotient, eq);
            chk("bp_hold_remainder", remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        run_op("b2b", 32'h7FFF_FFFF, 32'd3, 1'b1);

        // Randomized operands across both signednesses and divisor classes.
        for (int n = 0; n < 24; n++) begin
            ra   = $urandom;
            mode = int'($urandom_range(0, 4));
            case (mode)
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'd0;
                3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if (n == 3) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            run_op("rand", ra, rb, rs);
        end

        // Flush mid-iteration: no result may appear.
        issue(32'd12345, 32'd17, 1'b0);
        repeat (11) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("cancel_out_valid", {31'd0, out_valid}, 32'd0);
        rose = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) rose++;
        end
        chk("cancel_no_result", 32'(rose), 32'd0);

        // Cancel held in IDLE blocks acceptance.
        cancel   = 1'b1;
        src1     = 32'd9;
        src2     = 32'd3;
        sign     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cancel   = 1'b0;
        chk("cancel_idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset while iterating.
        issue(32'd5555, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("areset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("areset_quotient", quotient, 32'd0);
        chk("areset_remainder", remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("post_reset", 32'hFFFF_FFFF, 32'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
